// File: rtl/pow2_array.sv
// pow2_array: multi-lane signed fixed-point squaring pipeline with valid/ready flow control.
// Each lane returns round(x*x >> Q), the sign-extended operand (pass), or 0 (masked).
// Three register stages (operand, product, result) advance together on ce = m_ready | ~m_valid.
// Build option: define POW2_ARRAY_SAT_EN to clamp oversized squares to the signed W-bit
// maximum; without it the square wraps to its low W bits and is sign-extended.
module pow2_array #(
  parameter int LANES            = 4,
  parameter int INFO_ALONG_WIDTH = 2,
  parameter bit EN_ROUND         = 1'b1,
  parameter int SIM_DELAY        = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [1:0]                  s_calfmt,
  input  logic [4:0]                  s_quat_accrc,
  input  logic [LANES*32-1:0]         s_op_x,
  input  logic [LANES-1:0]            s_lane_en,
  input  logic                        s_pass,
  input  logic [INFO_ALONG_WIDTH-1:0] s_info_along,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [LANES*32-1:0]         m_res,
  output logic [INFO_ALONG_WIDTH-1:0] m_info_along,
  output logic                        m_valid,
  input  logic                        m_ready
);

  // Register updates in this model are zero-delay; the delay value is kept for interface compatibility.
  localparam int unused_sim_delay = SIM_DELAY;

  logic                        ce;
  logic                        in_is16;
  logic [LANES-1:0][31:0]      in_x;

  logic                        s1_valid_q;
  logic                        s1_is16_q;
  logic [4:0]                  s1_frac_q;
  logic [LANES-1:0]            s1_en_q;
  logic                        s1_pass_q;
  logic [INFO_ALONG_WIDTH-1:0] s1_info_q;
  logic [LANES-1:0][31:0]      s1_x_q;

  logic [LANES-1:0][63:0]      s2_prod_d;
  logic                        s2_valid_q;
  logic                        s2_is16_q;
  logic [4:0]                  s2_frac_q;
  logic [LANES-1:0]            s2_en_q;
  logic                        s2_pass_q;
  logic [INFO_ALONG_WIDTH-1:0] s2_info_q;
  logic [LANES-1:0][31:0]      s2_x_q;
  logic [LANES-1:0][63:0]      s2_prod_q;

  logic [63:0]                 s3_rnd;
  logic [LANES-1:0][63:0]      s3_shr;
  logic [LANES-1:0][31:0]      s3_sq;
  logic [LANES-1:0][31:0]      s3_res_d;

  logic                        m_valid_q;
  logic [LANES-1:0][31:0]      m_res_q;
  logic [INFO_ALONG_WIDTH-1:0] m_info_q;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign ce      = m_ready | ~m_valid_q;
  assign s_ready = ce;
  assign in_is16 = (s_calfmt == 2'b00);

  // Sign-extend every lane operand from the beat's width (16 or 32) to 32 bits.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    in_x = '0;
    for (int i = 0; i < LANES; i++) begin
      in_x[i] = in_is16 ? {{16{s_op_x[32*i+15]}}, s_op_x[32*i +: 16]} : s_op_x[32*i +: 32];
    end
  end

  // Stage 1: capture operands and the per-beat controls that travel with them.
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: data registers are reset along with valids so the outputs read 0 out of reset.
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_is16_q  <= 1'b0;
      s1_frac_q  <= '0;
      s1_en_q    <= '0;
      s1_pass_q  <= 1'b0;
      s1_info_q  <= '0;
      s1_x_q     <= '0;
    end else if (ce) begin
      // NOTE: non-blocking updates make every stage see the pre-edge value of the one before.
      s1_valid_q <= s_valid;
      if (s_valid) begin
        s1_is16_q <= in_is16;
        s1_frac_q <= s_quat_accrc;
        s1_en_q   <= s_lane_en;
        s1_pass_q <= s_pass;
        s1_info_q <= s_info_along;
        s1_x_q    <= in_x;
      end
    end
  end

  // Square each lane at 64-bit width; a value times itself is never negative.
  always_comb begin
    s2_prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_prod_d[i] = $signed({{32{s1_x_q[i][31]}}, s1_x_q[i]})
                   * $signed({{32{s1_x_q[i][31]}}, s1_x_q[i]});
    end
  end

  // Stage 2: register the products together with the beat controls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s2_valid_q <= 1'b0;
      s2_is16_q  <= 1'b0;
      s2_frac_q  <= '0;
      s2_en_q    <= '0;
      s2_pass_q  <= 1'b0;
      s2_info_q  <= '0;
      s2_x_q     <= '0;
      s2_prod_q  <= '0;
    end else if (ce) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_is16_q <= s1_is16_q;
        s2_frac_q <= s1_frac_q;
        s2_en_q   <= s1_en_q;
        s2_pass_q <= s1_pass_q;
        s2_info_q <= s1_info_q;
        s2_x_q    <= s1_x_q;
        s2_prod_q <= s2_prod_d;
      end
    end
  end

  // Half-up rounding constant: 2^(Q-1) when rounding is enabled and fraction bits are dropped.
  assign s3_rnd = (EN_ROUND && (s2_frac_q != 5'd0)) ? (64'd1 << (s2_frac_q - 5'd1)) : 64'd0;

  // Round and shift every lane's product; the sum cannot overflow 64 bits.
  always_comb begin
    s3_shr = '0;
    for (int i = 0; i < LANES; i++) begin
      s3_shr[i] = (s2_prod_q[i] + s3_rnd) >> s2_frac_q;
    end
  end

`ifdef POW2_ARRAY_SAT_EN
  // Clamp squares above the signed W-bit maximum to that maximum.
  always_comb begin
    s3_sq = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s2_is16_q) begin
        s3_sq[i] = (s3_shr[i] > 64'h0000_7FFF) ? 32'h0000_7FFF : s3_shr[i][31:0];
      end else begin
        s3_sq[i] = (s3_shr[i] > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : s3_shr[i][31:0];
      end
    end
  end
`else
  // Wrap: keep the low W bits of the square and sign-extend them; upper bits are discarded.
  logic unused_shr_hi;
  always_comb begin
    s3_sq         = '0;
    unused_shr_hi = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      s3_sq[i]      = s2_is16_q ? {{16{s3_shr[i][15]}}, s3_shr[i][15:0]} : s3_shr[i][31:0];
      unused_shr_hi = unused_shr_hi | (|s3_shr[i][63:32]);
    end
  end
`endif

  // Select square or pass-through per lane, then force masked lanes to zero.
  always_comb begin
    s3_res_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!s2_en_q[i]) begin
        s3_res_d[i] = '0;
      end else if (s2_pass_q) begin
        s3_res_d[i] = s2_x_q[i];
      end else begin
        s3_res_d[i] = s3_sq[i];
      end
    end
  end

  // Stage 3: output register, held while the consumer stalls.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_valid_q <= 1'b0;
      m_res_q   <= '0;
      m_info_q  <= '0;
    end else if (ce) begin
      m_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        m_res_q  <= s3_res_d;
        m_info_q <= s2_info_q;
      end
    end
  end

  assign m_valid      = m_valid_q;
  assign m_res        = m_res_q;
  assign m_info_along = m_info_q;

endmodule

// File: tb/tb_pow2_array.sv
// Self-checking bench for pow2_array: directed cases plus randomized traffic under
// back-pressure, scored against an arithmetic reference model and an in-order queue.
module tb_pow2_array;
  localparam int LANES    = 4;
  localparam int IW       = 2;
  localparam bit EN_ROUND = 1'b1;
  localparam int XW       = LANES * 32;

  logic          aclk   = 1'b0;
  logic          areset = 1'b0;
  logic [1:0]    s_calfmt;
  logic [4:0]    s_quat_accrc;
  logic [XW-1:0] s_op_x;
  logic [LANES-1:0] s_lane_en;
  logic          s_pass;
  logic [IW-1:0] s_info_along;
  logic          s_valid;
  logic          s_ready;
  logic [XW-1:0] m_res;
  logic [IW-1:0] m_info_along;
  logic          m_valid;
  logic          m_ready;

  pow2_array #(
    .LANES(LANES), .INFO_ALONG_WIDTH(IW), .EN_ROUND(EN_ROUND), .SIM_DELAY(1)
  ) dut (
    .aclk(aclk), .areset(areset), .s_calfmt(s_calfmt), .s_quat_accrc(s_quat_accrc),
    .s_op_x(s_op_x), .s_lane_en(s_lane_en), .s_pass(s_pass), .s_info_along(s_info_along),
    .s_valid(s_valid), .s_ready(s_ready), .m_res(m_res), .m_info_along(m_info_along),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [XW-1:0] res;
    logic [IW-1:0] info;
  } out_t;

  out_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_out   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: 1,0,0 repeating
  int   rcnt    = 0;

  task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: square of the W-bit signed operand, rounded, shifted, clipped, masked.
  function automatic logic [31:0] model_lane(input logic [1:0] fmt, input logic [4:0] q,
                                             input logic [31:0] raw, input logic en,
                                             input logic pass);
    int     w;
    longint x, p, maxv;
    w = (fmt == 2'b00) ? 16 : 32;
    if (!en) return 32'h0;
    x = (w == 16) ? longint'($signed(raw[15:0])) : longint'($signed(raw));
    if (pass) return x[31:0];
    p = x * x;
    if (EN_ROUND && q != 0) p = p + (longint'(1) << (int'(q) - 1));
    p = p >>> q;
    maxv = (longint'(1) << (w - 1)) - 1;
`ifdef POW2_ARRAY_SAT_EN
    if (p > maxv) p = maxv;
`endif
    if (w == 16) return {{16{p[15]}}, p[15:0]};
    return p[31:0];
  endfunction

  function automatic out_t model_beat();
    out_t o;
    for (int i = 0; i < LANES; i++) begin
      o.res[32*i +: 32] = model_lane(s_calfmt, s_quat_accrc, s_op_x[32*i +: 32], s_lane_en[i], s_pass);
    end
    o.info = s_info_along;
    return o;
  endfunction

  // Output handshake driver.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        1:       m_ready = ($urandom_range(0, 9) < 6);
        2:       begin m_ready = (rcnt % 3 == 0); rcnt++; end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: mid-cycle sampling, in-order scoreboard, handshake rule, reset values.
  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        sb.delete();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_res", m_res, '0);
        check("rst_m_info", m_info_along, '0);
      end else begin
        check("s_ready_rule", s_ready, !(m_valid && !m_ready));
        if (m_valid) begin
          if (sb.size() == 0) begin
            check("spurious_valid", m_valid, 1'b0);
          end else begin
            check("m_res", m_res, sb[0].res);
            check("m_info", m_info_along, sb[0].info);
            if (m_ready) begin
              void'(sb.pop_front());
              n_out++;
            end
          end
        end
        if (s_valid && s_ready) sb.push_back(model_beat());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [1:0] fmt, input logic [4:0] q, input logic [XW-1:0] x,
                      input logic [LANES-1:0] en, input logic pass, input logic [IW-1:0] info);
    int n;
    bit done;
    s_calfmt = fmt; s_quat_accrc = q; s_op_x = x; s_lane_en = en; s_pass = pass;
    s_info_along = info; s_valid = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge aclk);
      done = s_ready;
      @(posedge aclk); #1;
      n++;
      if (!done && n >= 100) begin
        check("accept_timeout", n, 0);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 300) begin
      @(posedge aclk); #1;
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  // One beat into an empty pipe with m_ready high: m_valid exactly 3 cycles after the handshake.
  task automatic directed(input string tag, input logic [1:0] fmt, input logic [4:0] q,
                          input logic [XW-1:0] x, input logic [LANES-1:0] en, input logic pass,
                          input logic [IW-1:0] info, input logic [XW-1:0] exp);
    send(fmt, q, x, en, pass, info);
    idle();
    @(negedge aclk); check({tag, "_lat1"}, m_valid, 1'b0);
    @(negedge aclk); check({tag, "_lat2"}, m_valid, 1'b0);
    @(negedge aclk); check({tag, "_lat3"}, m_valid, 1'b1);
    check({tag, "_res"}, m_res, exp);
    check({tag, "_info"}, m_info_along, info);
    @(posedge aclk); #1;
  endtask

  task automatic send_random(input logic [IW-1:0] info);
    logic [XW-1:0] x;
    logic [31:0]   v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 7))
        0:       v = 32'h0000_7FFF;
        1:       v = 32'h0000_8000;
        2:       v = 32'h7FFF_FFFF;
        3:       v = 32'h8000_0000;
        4:       v = 32'($urandom_range(0, 255)) - 32'd128;
        default: v = $urandom();
      endcase
      x[32*i +: 32] = v;
    end
    send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), x,
         LANES'($urandom() | $urandom()), ($urandom_range(0, 7) == 0), info);
  endtask

  logic [XW-1:0] ops;
  int            base;

  initial begin
    s_valid = 1'b0; s_calfmt = '0; s_quat_accrc = '0; s_op_x = '0;
    s_lane_en = '0; s_pass = 1'b0; s_info_along = '0;
    #1 areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_m_valid", m_valid, 1'b0);
    @(posedge aclk); #1;

    // Squares, pass-through and masking on INT32, Q=8.
    ops = {32'd0, 32'hFFFF_F893, 32'd803, 32'd40};
    directed("int32_sq", 2'b01, 5'd8, ops, 4'b1111, 1'b0, 2'b01,
             {32'd0, 32'd14116, 32'd2519, 32'd6});
    directed("int32_pass", 2'b01, 5'd8, ops, 4'b1111, 1'b1, 2'b10, ops);
    directed("int32_mask", 2'b01, 5'd8, ops, 4'b0101, 1'b0, 2'b11,
             {32'd0, 32'd14116, 32'd0, 32'd6});

    // INT16 overflow, small negative operand (upper bits ignored), INT32 overflow via fmt 2'b11.
`ifdef POW2_ARRAY_SAT_EN
    directed("int16_ovf", 2'b00, 5'd5, {96'd0, 32'h0000_7FFF}, 4'b1111, 1'b0, 2'b00,
             {96'd0, 32'h0000_7FFF});
    directed("int32_ovf", 2'b11, 5'd0, {96'd0, 32'h8000_0000}, 4'b0001, 1'b0, 2'b01,
             {96'd0, 32'h7FFF_FFFF});
`else
    directed("int16_ovf", 2'b00, 5'd5, {96'd0, 32'h0000_7FFF}, 4'b1111, 1'b0, 2'b00,
             {96'd0, 32'hFFFF_F800});
    directed("int32_ovf", 2'b11, 5'd0, {96'd0, 32'h8000_0000}, 4'b0001, 1'b0, 2'b01,
             {96'd0, 32'h0000_0000});
`endif
    directed("int16_neg", 2'b00, 5'd5, {96'd0, 32'hABCD_FFD8}, 4'b1111, 1'b0, 2'b10,
             {96'd0, 32'd50});

    // Mixed formats back to back with distinct side-band.
    send(2'b01, 5'd8, {96'd0, 32'd40}, 4'b1111, 1'b0, 2'b01);
    send(2'b00, 5'd5, {96'd0, 32'h0000_FFD8}, 4'b1111, 1'b0, 2'b10);
    idle();
    @(negedge aclk); check("mixed_lat", m_valid, 1'b0);
    @(negedge aclk); check("mixed_v1", m_valid, 1'b1);
    check("mixed_res1", m_res, {96'd0, 32'd6});
    check("mixed_info1", m_info_along, 2'b01);
    @(negedge aclk); check("mixed_v2", m_valid, 1'b1);
    check("mixed_res2", m_res, {96'd0, 32'd50});
    check("mixed_info2", m_info_along, 2'b10);
    drain("mixed");

    // Eight beats under the 1,0,0 ready pattern.
    rdy_mode = 2; rcnt = 0;
    @(posedge aclk); #1;
    base = n_out;
    for (int i = 0; i < 8; i++) send_random(IW'(i));
    idle();
    drain("bp8");
    check("bp8_count", n_out - base, 8);

    // Randomized traffic with random gaps and random back-pressure.
    rdy_mode = 1;
    @(posedge aclk); #1;
    base = n_out;
    for (int i = 0; i < 300; i++) begin
      send_random(IW'($urandom()));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) begin @(posedge aclk); #1; end
      end
    end
    idle();
    drain("rand");
    check("rand_count", n_out - base, 300);

    // Reset with three beats in flight discards them all.
    rdy_mode = 0;
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) send(2'b01, 5'd8, ops, 4'b1111, 1'b0, IW'(i));
    idle();
    areset = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_res", m_res, '0);
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("post_rst_quiet", m_valid, 1'b0);
    end
    @(posedge aclk); #1;
    directed("post_rst", 2'b01, 5'd8, ops, 4'b1111, 1'b0, 2'b11,
             {32'd0, 32'd14116, 32'd2519, 32'd6});
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
